// File: rtl/sram_access_ctrl.sv
// sram_access_ctrl: runs each MEM-stage 32-bit load/store as two halfword accesses
// (low half first) on an async 16-bit SRAM, stalling the pipeline until done.
module sram_access_ctrl #(
    parameter int ADDR_BASE   = 1024,
    parameter int WAIT_CYCLES = 2,
    parameter int SRAM_ADDR_W = 18
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [31:0]            alu_res_in,
    input  logic [31:0]            val_rm_in,
    input  logic                   mem_read_enable_in,
    input  logic                   mem_write_enable_in,
    output logic [31:0]            read_data_out,
    output logic                   ready_out,
    output logic                   freeze_out,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    output logic [15:0]            sram_dq_out,
    output logic                   sram_dq_oe,
    input  logic [15:0]            sram_dq_in,
    output logic                   sram_we_n,
    output logic                   sram_oe_n
);
    localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] LAST = CW'(WAIT_CYCLES);
    localparam int WW = SRAM_ADDR_W - 1;

    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic          wr_q;
    logic [WW-1:0] word_q;
    logic [31:0]   data_q;
    logic [15:0]   lo_q;
    logic          req, phase, last;

    assign req = mem_read_enable_in | mem_write_enable_in;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        phase       = (state == LO) || (state == HI);
        last        = cnt == LAST;
        state_nxt   = state == IDLE ? (req ? LO : IDLE) :
                      state == DONE ? IDLE :
                      last ? state_t'(state + 2'd1) : state;
        freeze_out  = (state == IDLE && req && rst) || phase;
        ready_out   = state == DONE;
        sram_we_n   = !(phase && wr_q);
        sram_oe_n   = !(phase && !wr_q);
        sram_dq_oe  = phase && wr_q;
        sram_addr   = {word_q, state == HI};
        sram_dq_out = state == HI ? data_q[31:16] : data_q[15:0];
    end

    // Phase counter restarts at zero on entry to each halfword phase.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt           <= '0;
            wr_q          <= 1'b0;
            word_q        <= '0;
            data_q        <= '0;
            lo_q          <= '0;
            read_data_out <= '0;
        end else begin
            cnt <= (phase && !last) ? cnt + 1'b1 : '0;
            if (state == IDLE && req) begin
                wr_q   <= mem_write_enable_in;
                word_q <= WW'((alu_res_in - 32'(ADDR_BASE)) >> 2);
                data_q <= val_rm_in;
            end
            if (state == LO && last) lo_q <= sram_dq_in;
            if (state == HI && last && !wr_q) read_data_out <= {sram_dq_in, lo_q};
        end
    end
endmodule
